// File: rtl/mem_port2_arbiter_pkg.sv
// Shared types for the OTTER BRAM port-2 arbiter: FSM states, access sizes,
// the latched request payload and the size/offset legality check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } mem_req_t;

  // Half-words may sit at any offset that keeps both bytes in one word.
  function automatic logic align_ok(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: align_ok = 1'b1;
      SZ_HALF: align_ok = (offset != 2'd3);
      SZ_WORD: align_ok = (offset == 2'd0);
      default: align_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port2_arbiter_if.sv
// Requester and memory-side signal bundle for the port-2 arbiter.
// slave = arbiter view, master = requesters plus memory (testbench / SoC side).
interface mem_port2_arbiter_if;
  logic        R0_REQ,    R1_REQ;
  logic        R0_WE,     R1_WE;
  logic [31:0] R0_ADDR,   R1_ADDR;
  logic [31:0] R0_DIN,    R1_DIN;
  logic [1:0]  R0_SIZE,   R1_SIZE;
  logic        R0_SIGN,   R1_SIGN;
  logic        R0_GNT,    R1_GNT;
  logic        R0_ERR,    R1_ERR;
  logic        R0_RVALID, R1_RVALID;
  logic [31:0] R0_RDATA,  R1_RDATA;
  logic        MEM_RDEN2, MEM_WE2;
  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;
  logic        BUSY;

  modport slave (
    input  R0_REQ, R1_REQ, R0_WE, R1_WE, R0_ADDR, R1_ADDR, R0_DIN, R1_DIN,
           R0_SIZE, R1_SIZE, R0_SIGN, R1_SIGN, MEM_DOUT2,
    output R0_GNT, R1_GNT, R0_ERR, R1_ERR, R0_RVALID, R1_RVALID, R0_RDATA, R1_RDATA,
           MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, BUSY
  );

  modport master (
    output R0_REQ, R1_REQ, R0_WE, R1_WE, R0_ADDR, R1_ADDR, R0_DIN, R1_DIN,
           R0_SIZE, R1_SIZE, R0_SIGN, R1_SIGN, MEM_DOUT2,
    input  R0_GNT, R1_GNT, R0_ERR, R1_ERR, R0_RVALID, R1_RVALID, R0_RDATA, R1_RDATA,
           MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, BUSY
  );
endinterface

// File: rtl/mem_port2_arbiter_pick.sv
// Winner selection for the two port-2 requesters (pick: 0 = R0, 1 = R1).
// MEM_ARB_RR_EN selects round-robin on ties; otherwise R0 has fixed priority.
module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic grant,
`endif
  input  logic r0_req,
  input  logic r1_req,
  output logic pick
);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Starts at R1 so the first tie after reset goes to R0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= 1'b1;
    else if (grant) last_q <= pick;
  end

  always_comb begin
    pick = 1'b0;
    if (r0_req && r1_req) pick = ~last_q;
    else if (r1_req)      pick = 1'b1;
  end
`else
  assign pick = ~r0_req & r1_req;
`endif

endmodule

// File: rtl/mem_port2_arbiter.sv
// Arbiter/sequencer sharing OTTER BRAM port 2 between the CPU (R0) and the loader (R1).
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed R0 priority.
//
// state  | meaning
// IDLE   | waiting; samples REQs and latches the winner's payload
// ACCESS | payload on the memory port, enables asserted, winner's GNT high
// DATA   | load data returning; address/size/sign held for memory-side sizing
module mem_port2_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic           MEM_CLK,
  input logic           MEM_RST_N,
  mem_port2_arbiter_if.slave bus
);

  arb_state_t  state, state_nxt;
  mem_req_t    req_q, req_sel;
  logic        win_q, rej_q, rvalid_q;
  logic        pick, any_req, accept, sample, gnt;
  logic [31:0] r0_rdata_q, r1_rdata_q;

  assign any_req = bus.R0_REQ | bus.R1_REQ;
  assign sample  = (state == IDLE) && any_req;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk    (MEM_CLK),
    .rst_n  (MEM_RST_N),
    .grant  (sample),
`endif
    .r0_req (bus.R0_REQ),
    .r1_req (bus.R1_REQ),
    .pick   (pick)
  );

  always_comb begin
    if (pick) req_sel = '{we: bus.R1_WE, addr: bus.R1_ADDR, din: bus.R1_DIN,
                          size: bus.R1_SIZE, sign: bus.R1_SIGN};
    else      req_sel = '{we: bus.R0_WE, addr: bus.R0_ADDR, din: bus.R0_DIN,
                          size: bus.R0_SIZE, sign: bus.R0_SIGN};
  end

  assign accept = (CHECK_ALIGN == 1'b0) || align_ok(req_sel.size, req_sel.addr[1:0]);

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = (req_q.we || rej_q) ? IDLE : DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      req_q      <= '0;
      win_q      <= 1'b0;
      rej_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      rvalid_q <= (state == DATA);
      if (sample) begin
        req_q <= req_sel;
        win_q <= pick;
        rej_q <= ~accept;
      end
      if (state == DATA) begin
        if (win_q) r1_rdata_q <= bus.MEM_DOUT2;
        else       r0_rdata_q <= bus.MEM_DOUT2;
      end
    end
  end

  // Payload stays on the port after the access so sizing stays stable through DATA.
  assign gnt           = (state == ACCESS);
  assign bus.MEM_RDEN2 = gnt & ~req_q.we & ~rej_q;
  assign bus.MEM_WE2   = gnt &  req_q.we & ~rej_q;
  assign bus.MEM_ADDR2 = req_q.addr;
  assign bus.MEM_DIN2  = req_q.din;
  assign bus.MEM_SIZE  = req_q.size;
  assign bus.MEM_SIGN  = req_q.sign;
  assign bus.BUSY      = (state != IDLE);

  assign bus.R0_GNT    = gnt & ~win_q;
  assign bus.R1_GNT    = gnt &  win_q;
  assign bus.R0_ERR    = gnt & rej_q & ~win_q;
  assign bus.R1_ERR    = gnt & rej_q &  win_q;
  assign bus.R0_RVALID = rvalid_q & ~win_q;
  assign bus.R1_RVALID = rvalid_q &  win_q;
  assign bus.R0_RDATA  = r0_rdata_q;
  assign bus.R1_RDATA  = r1_rdata_q;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed bench for mem_port2_arbiter with a small BRAM model on port 2.
module tb_mem_port2_arbiter;

  logic MEM_CLK;
  logic MEM_RST_N;
  int   total;
  int   bad;

  mem_port2_arbiter_if bus ();

  mem_port2_arbiter #(.CHECK_ALIGN(1'b1)) dut (
    .MEM_CLK   (MEM_CLK),
    .MEM_RST_N (MEM_RST_N),
    .bus       (bus)
  );

  initial MEM_CLK = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  // BRAM model: registered word read, combinational sizing on the live port inputs.
  logic [31:0] mem [0:16383];
  logic [31:0] rd_word;
  logic [31:0] io_in;

  always @(posedge MEM_CLK) begin
    logic [31:0] w;
    logic [1:0]  off;
    off = bus.MEM_ADDR2[1:0];
    w   = mem[bus.MEM_ADDR2[15:2]];
    if (bus.MEM_WE2 && bus.MEM_ADDR2 < 32'h0001_0000) begin
      case (bus.MEM_SIZE)
        2'd0:    w[8*off +: 8] = bus.MEM_DIN2[7:0];
        2'd1:    w[8*off +: 16] = bus.MEM_DIN2[15:0];
        default: w = bus.MEM_DIN2;
      endcase
      mem[bus.MEM_ADDR2[15:2]] <= w;
    end
    if (bus.MEM_RDEN2)
      rd_word <= (bus.MEM_ADDR2 < 32'h0001_0000) ? mem[bus.MEM_ADDR2[15:2]] : io_in;
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd_word >> {bus.MEM_ADDR2[1:0], 3'b000});
    h = 16'(rd_word >> {bus.MEM_ADDR2[1:0], 3'b000});
    case (bus.MEM_SIZE)
      2'd0:    bus.MEM_DOUT2 = bus.MEM_SIGN ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    bus.MEM_DOUT2 = bus.MEM_SIGN ? {16'h0, h} : {{16{h[15]}}, h};
      default: bus.MEM_DOUT2 = rd_word;
    endcase
  end

  function automatic logic [139:0] all_outs();
    return {bus.R0_GNT, bus.R1_GNT, bus.R0_ERR, bus.R1_ERR, bus.R0_RVALID, bus.R1_RVALID,
            bus.R0_RDATA, bus.R1_RDATA, bus.MEM_RDEN2, bus.MEM_WE2, bus.MEM_ADDR2,
            bus.MEM_DIN2, bus.MEM_SIZE, bus.MEM_SIGN, bus.BUSY};
  endfunction

  task automatic apply_reset();
    MEM_RST_N  = 1'b0;
    bus.R0_REQ = 1'b0;
    bus.R1_REQ = 1'b0;
    repeat (2) @(posedge MEM_CLK);
    #1 MEM_RST_N = 1'b1;
    @(posedge MEM_CLK);
    #1;
  endtask

  // One request on one port; observes 6 cycles and reports first-seen cycle numbers.
  task automatic run_txn(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] din, input logic [1:0] size, input logic sign,
                         output int gnt_n, output int err_n, output int rv_n,
                         output logic [1:0] d_size, output logic [1:0] d_off,
                         output logic rden_any, output logic other_any);
    logic mg, me, mv, og;
    gnt_n = 0; err_n = 0; rv_n = 0; d_size = 2'd0; d_off = 2'd0;
    rden_any = 1'b0; other_any = 1'b0;
    if (!port) begin
      bus.R0_WE = we; bus.R0_ADDR = addr; bus.R0_DIN = din;
      bus.R0_SIZE = size; bus.R0_SIGN = sign; bus.R0_REQ = 1'b1;
    end else begin
      bus.R1_WE = we; bus.R1_ADDR = addr; bus.R1_DIN = din;
      bus.R1_SIZE = size; bus.R1_SIGN = sign; bus.R1_REQ = 1'b1;
    end
    for (int n = 1; n <= 6; n++) begin
      @(posedge MEM_CLK);
      #1;
      if (gnt_n != 0 && n == gnt_n + 1) begin
        bus.R0_REQ = 1'b0;
        bus.R1_REQ = 1'b0;
      end
      mg = port ? bus.R1_GNT : bus.R0_GNT;
      me = port ? bus.R1_ERR : bus.R0_ERR;
      mv = port ? bus.R1_RVALID : bus.R0_RVALID;
      og = port ? (bus.R0_GNT | bus.R0_ERR | bus.R0_RVALID)
                : (bus.R1_GNT | bus.R1_ERR | bus.R1_RVALID);
      if (mg && gnt_n == 0) gnt_n = n;
      if (me && err_n == 0) err_n = n;
      if (mv && rv_n == 0)  rv_n = n;
      if (n == 2) begin
        d_size = bus.MEM_SIZE;
        d_off  = bus.MEM_ADDR2[1:0];
      end
      if (bus.MEM_RDEN2) rden_any = 1'b1;
      if (og) other_any = 1'b1;
    end
    bus.R0_REQ = 1'b0;
    bus.R1_REQ = 1'b0;
  endtask

  task automatic test_reset();
    MEM_RST_N = 1'b0;
    #1;
    total++;
    if (all_outs() !== 140'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    apply_reset();
    total++;
    if (all_outs() !== 140'd0) begin
      bad++; $display("FAIL idle_after_reset: got %h want 0", all_outs());
    end
  endtask

  task automatic test_word_store_load();
    int g, e, v; logic [1:0] ds, doff; logic rd, oth;
    run_txn(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if ({g, e, v} !== {32'd1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL r0_store_timing: got gnt=%0d err=%0d rv=%0d want 1 0 0", g, e, v);
    end
    total++;
    if (mem[32'h40] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL r0_store_mem: got %h want deadbeef", mem[32'h40]);
    end
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if ({g, e, v, oth} !== {32'd1, 32'd0, 32'd3, 1'b0}) begin
      bad++; $display("FAIL r0_load_timing: got gnt=%0d err=%0d rv=%0d other=%0b want 1 0 3 0", g, e, v, oth);
    end
    total++;
    if (bus.R0_RDATA !== 32'hDEADBEEF) begin
      bad++; $display("FAIL r0_load_data: got %h want deadbeef", bus.R0_RDATA);
    end
  endtask

  task automatic test_byte_sign();
    int g, e, v; logic [1:0] ds, doff; logic rd, oth;
    run_txn(1'b1, 1'b1, 32'h203, 32'h0000_0080, 2'd0, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if (mem[32'h80] !== 32'h8000_0000) begin
      bad++; $display("FAIL r1_byte_store: got %h want 80000000", mem[32'h80]);
    end
    run_txn(1'b1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if ({bus.R1_RDATA, ds, doff, v[1:0]} !== {32'hFFFF_FF80, 2'd0, 2'd3, 2'd3}) begin
      bad++; $display("FAIL r1_signed_byte: got data=%h size=%0d off=%0d rv=%0d want ffffff80 0 3 3",
                      bus.R1_RDATA, ds, doff, v);
    end
    run_txn(1'b1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b1, g, e, v, ds, doff, rd, oth);
    total++;
    if ({bus.R1_RDATA, ds, doff, oth} !== {32'h0000_0080, 2'd0, 2'd3, 1'b0}) begin
      bad++; $display("FAIL r1_unsigned_byte: got data=%h size=%0d off=%0d other=%0b want 00000080 0 3 0",
                      bus.R1_RDATA, ds, doff, oth);
    end
  endtask

  task automatic test_align();
    int g, e, v; logic [1:0] ds, doff; logic rd, oth;
    run_txn(1'b0, 1'b0, 32'h102, 32'h0, 2'd2, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if ({g, e, v, rd} !== {32'd1, 32'd1, 32'd0, 1'b0}) begin
      bad++; $display("FAIL misaligned_word: got gnt=%0d err=%0d rv=%0d rden=%0b want 1 1 0 0", g, e, v, rd);
    end
    total++;
    if (bus.R0_RDATA !== 32'hDEADBEEF) begin
      bad++; $display("FAIL misaligned_rdata_kept: got %h want deadbeef", bus.R0_RDATA);
    end
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 2'd3, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if ({e, v, rd, bus.R1_RDATA} !== {32'd1, 32'd0, 1'b0, 32'h0000_0080}) begin
      bad++; $display("FAIL size3_reject: got err=%0d rv=%0d rden=%0b data=%h want 1 0 0 00000080",
                      e, v, rd, bus.R1_RDATA);
    end
    run_txn(1'b0, 1'b0, 32'h101, 32'h0, 2'd1, 1'b1, g, e, v, ds, doff, rd, oth);
    total++;
    if ({e, v, bus.R0_RDATA} !== {32'd0, 32'd3, 32'h0000_ADBE}) begin
      bad++; $display("FAIL half_off1: got err=%0d rv=%0d data=%h want 0 3 0000adbe", e, v, bus.R0_RDATA);
    end
  endtask

  task automatic test_io();
    int g, e, v; logic [1:0] ds, doff; logic rd, oth;
    io_in = 32'h1234_5678;
    run_txn(1'b1, 1'b0, 32'h1100_0000, 32'h0, 2'd2, 1'b0, g, e, v, ds, doff, rd, oth);
    total++;
    if ({g, v, bus.R1_RDATA} !== {32'd1, 32'd3, 32'h1234_5678}) begin
      bad++; $display("FAIL io_load: got gnt=%0d rv=%0d data=%h want 1 3 12345678", g, v, bus.R1_RDATA);
    end
  endtask

  task automatic test_tie();
    logic [3:0] seq, exp_seq;
    int         cnt;
    logic       both;
`ifdef MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    apply_reset();
    seq = 4'b0; cnt = 0; both = 1'b0;
    bus.R0_WE = 1'b1; bus.R0_ADDR = 32'h300; bus.R0_DIN = 32'h1111_1111;
    bus.R0_SIZE = 2'd2; bus.R0_SIGN = 1'b0;
    bus.R1_WE = 1'b1; bus.R1_ADDR = 32'h304; bus.R1_DIN = 32'h2222_2222;
    bus.R1_SIZE = 2'd2; bus.R1_SIGN = 1'b0;
    bus.R0_REQ = 1'b1; bus.R1_REQ = 1'b1;
    for (int n = 0; n < 20 && cnt < 4; n++) begin
      @(posedge MEM_CLK);
      #1;
      if (bus.R0_GNT && bus.R1_GNT) both = 1'b1;
      if (bus.R0_GNT || bus.R1_GNT) begin
        seq[cnt] = bus.R1_GNT;
        cnt++;
      end
    end
    bus.R0_REQ = 1'b0; bus.R1_REQ = 1'b0;
    total++;
    if (cnt !== 4 || both !== 1'b0) begin
      bad++; $display("FAIL tie_grants: got count=%0d double=%0b want 4 0", cnt, both);
    end
    total++;
    if (seq !== exp_seq) begin
      bad++; $display("FAIL tie_order: got %b want %b (bit i set = grant i to R1)", seq, exp_seq);
    end
    repeat (3) @(posedge MEM_CLK);
    #1;
  endtask

  task automatic test_reset_mid_store();
    mem[32'h10] = 32'h0BAD_F00D;
    bus.R0_WE = 1'b1; bus.R0_ADDR = 32'h40; bus.R0_DIN = 32'hCAFE_F00D;
    bus.R0_SIZE = 2'd2; bus.R0_SIGN = 1'b0; bus.R0_REQ = 1'b1;
    @(posedge MEM_CLK);
    #1;
    total++;
    if ({bus.BUSY, bus.MEM_WE2, bus.R0_GNT} !== 3'b111) begin
      bad++; $display("FAIL midrst_access: got busy/we/gnt=%b want 111", {bus.BUSY, bus.MEM_WE2, bus.R0_GNT});
    end
    #2 MEM_RST_N = 1'b0;
    #1;
    total++;
    if (all_outs() !== 140'd0) begin
      bad++; $display("FAIL midrst_async_clear: got %h want 0", all_outs());
    end
    bus.R0_REQ = 1'b0;
    @(posedge MEM_CLK);
    #1;
    total++;
    if (mem[32'h10] !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL midrst_no_store: got %h want 0badf00d", mem[32'h10]);
    end
    total++;
    if (all_outs() !== 140'd0) begin
      bad++; $display("FAIL midrst_held: got %h want 0", all_outs());
    end
    MEM_RST_N = 1'b1;
    @(posedge MEM_CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    io_in = 32'h0;
    rd_word = 32'h0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    MEM_RST_N = 1'b0;
    bus.R0_REQ = 1'b0; bus.R0_WE = 1'b0; bus.R0_ADDR = '0; bus.R0_DIN = '0;
    bus.R0_SIZE = '0; bus.R0_SIGN = 1'b0;
    bus.R1_REQ = 1'b0; bus.R1_WE = 1'b0; bus.R1_ADDR = '0; bus.R1_DIN = '0;
    bus.R1_SIZE = '0; bus.R1_SIGN = 1'b0;
    test_reset();
    test_word_store_load();
    test_byte_sign();
    test_align();
    test_io();
    test_tie();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
